// File: rtl/evm_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
//   Shared definitions for the EVM session controller slice.
//   - Default parameter values for voter/candidate widths and cycle budgets.
//   - Session FSM state enumeration.
//   - in_session(): true for every state in which polling is open.
// -----------------------------------------------------------------------------
package evm_pkg;

  localparam int DEF_VOTER_W        = 3;
  localparam int DEF_CAND_W         = 2;
  localparam int DEF_NUM_CANDIDATES = 3;
  localparam int DEF_TIMEOUT_CYC    = 64;
  localparam int DEF_COMMIT_CYC     = 2;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    AUTH,
    WAIT_VOTE,
    COMMIT,
    HOLD,
    CLOSED
  } state_t;

  function automatic logic in_session(input state_t s);
    return s inside {OPEN, AUTH, WAIT_VOTE, COMMIT, HOLD};
  endfunction

endpackage : evm_pkg

// File: rtl/evm_session_controller_if.sv
// -----------------------------------------------------------------------------
// evm_session_controller_if
//   Booth-side bundle between the session controller and its host.
//   master : the booth/host; drives session control, login and ballot inputs.
//   slave  : the session controller; drives datapath strobes and status.
//   Signals:
//     open_session, close_session  session control pulses
//     voter_valid, voter_id        booth login
//     vote_press, cand_sel         ballot button and chosen candidate
//     vote_signal                  one-cycle commit strobe to the datapath
//     voter_number, candidate_number  registered ballot fields to the datapath
//     session_open, booth_ready, reject, results_valid, ballots_cast  status
// -----------------------------------------------------------------------------
interface evm_session_controller_if #(
  parameter int VOTER_W = evm_pkg::DEF_VOTER_W,
  parameter int CAND_W  = evm_pkg::DEF_CAND_W
);

  logic               open_session;
  logic               close_session;
  logic               voter_valid;
  logic [VOTER_W-1:0] voter_id;
  logic               vote_press;
  logic [CAND_W-1:0]  cand_sel;

  logic               vote_signal;
  logic [VOTER_W-1:0] voter_number;
  logic [CAND_W-1:0]  candidate_number;
  logic               session_open;
  logic               booth_ready;
  logic               reject;
  logic               results_valid;
  logic [VOTER_W:0]   ballots_cast;

  modport master (
    output open_session, close_session, voter_valid, voter_id, vote_press, cand_sel,
    input  vote_signal, voter_number, candidate_number, session_open, booth_ready,
           reject, results_valid, ballots_cast
  );

  modport slave (
    input  open_session, close_session, voter_valid, voter_id, vote_press, cand_sel,
    output vote_signal, voter_number, candidate_number, session_open, booth_ready,
           reject, results_valid, ballots_cast
  );

endinterface : evm_session_controller_if

// File: rtl/evm_voter_registry.sv
// -----------------------------------------------------------------------------
// evm_voter_registry
//   One bit per voter ID recording whether that voter has cast a ballot.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (clears every bit)
//     clear        synchronous clear of the whole bitmap (new session)
//     set, set_id  mark voter set_id as having voted
//     query_id     voter being authenticated
//     voted        bitmap[query_id], read combinationally from the flops
// -----------------------------------------------------------------------------
module evm_voter_registry #(
  parameter int VOTER_W = evm_pkg::DEF_VOTER_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               set,
  input  logic [VOTER_W-1:0] set_id,
  input  logic [VOTER_W-1:0] query_id,
  output logic               voted
);

  localparam int NUM_VOTERS = 1 << VOTER_W;

  logic [NUM_VOTERS-1:0] bitmap_q;

  // NOTE: the bitmap is a flop array, not a RAM, so it takes the async reset;
  // a reset in the middle of a ballot must forget every voter at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '0;
    end else if (clear) begin
      bitmap_q <= '0;
    end else if (set) begin
      bitmap_q[set_id] <= 1'b1;
    end
  end

  assign voted = bitmap_q[query_id];

endmodule : evm_voter_registry

// File: rtl/evm_session_controller.sv
// -----------------------------------------------------------------------------
// evm_session_controller
//   Sequences one election session in front of the vote-counting datapath:
//   opens/closes polling, admits one voter at a time, blocks repeat voters,
//   rejects out-of-range candidates, abandons idle booths after TIMEOUT_CYC
//   cycles and issues one vote_signal strobe per accepted ballot.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    slave side of evm_session_controller_if (all session I/O)
//   Every output is driven from a flop; the flops are loaded from the
//   next-state value so each status output lines up with its state.
// -----------------------------------------------------------------------------
module evm_session_controller
  import evm_pkg::*;
#(
  parameter int VOTER_W        = DEF_VOTER_W,
  parameter int CAND_W         = DEF_CAND_W,
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
  parameter int COMMIT_CYC     = DEF_COMMIT_CYC   // must be >= 2
) (
  input logic                     clk,
  input logic                     rst_n,
  evm_session_controller_if.slave bus
);

  localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CAND_W:0]  NUM_CAND_L = (CAND_W+1)'(NUM_CANDIDATES);
  localparam logic [VOTER_W:0] BALLOT_MAX = (VOTER_W+1)'(1 << VOTER_W);

  state_t state_q, state_d;

  logic [VOTER_W-1:0] voter_number_q;
  logic [CAND_W-1:0]  candidate_number_q;
  logic [TIMER_W-1:0] timer_q;
  logic [VOTER_W:0]   ballots_q;
  logic               close_pending_q;

  logic vote_signal_q, session_open_q, booth_ready_q, reject_q, results_valid_q;
  logic vote_signal_d, session_open_d, booth_ready_d, reject_d, results_valid_d;

  logic voted;
  logic open_accept;
  logic valid_press;
  logic timer_expired;
  logic hold_done;
  logic close_seen;

  // Open is honoured only from IDLE/CLOSED; it also wipes the session history.
  assign open_accept   = (state_q == IDLE || state_q == CLOSED) && bus.open_session;
  assign valid_press   = bus.vote_press && ({1'b0, bus.cand_sel} < NUM_CAND_L);
  assign timer_expired = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));
  // The same timer counts HOLD cycles; it is zeroed on leaving COMMIT.
  assign hold_done     = (timer_q == TIMER_W'(COMMIT_CYC - 2));
  // A close seen while a ballot is in flight is remembered until it can act.
  assign close_seen    = close_pending_q | bus.close_session;

  evm_voter_registry #(
    .VOTER_W (VOTER_W)
  ) u_registry (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (open_accept),
    .set      (state_q == COMMIT),
    .set_id   (voter_number_q),
    .query_id (voter_number_q),
    .voted    (voted)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.open_session) state_d = OPEN;
      OPEN: begin
        if (close_seen)           state_d = CLOSED;
        else if (bus.voter_valid) state_d = AUTH;
      end
      AUTH:      state_d = voted ? OPEN : WAIT_VOTE;
      WAIT_VOTE: begin
        // A valid press beats the timeout in the same cycle.
        if (valid_press)        state_d = COMMIT;
        else if (timer_expired) state_d = OPEN;
      end
      COMMIT:    state_d = HOLD;
      HOLD:      if (hold_done) state_d = close_seen ? CLOSED : OPEN;
      CLOSED:    if (bus.open_session) state_d = OPEN;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    vote_signal_d   = (state_d == COMMIT);
    session_open_d  = in_session(state_d);
    booth_ready_d   = (state_d == OPEN);
    results_valid_d = (state_d == CLOSED);
    // Repeat voter, out-of-range press, or timeout; a bad press coinciding
    // with the timeout still yields a single pulse.
    reject_d        = ((state_q == AUTH) && voted) ||
                      ((state_q == WAIT_VOTE) && !valid_press &&
                       (bus.vote_press || timer_expired));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_signal_q   <= 1'b0;
      session_open_q  <= 1'b0;
      booth_ready_q   <= 1'b0;
      reject_q        <= 1'b0;
      results_valid_q <= 1'b0;
    end else begin
      vote_signal_q   <= vote_signal_d;
      session_open_q  <= session_open_d;
      booth_ready_q   <= booth_ready_d;
      reject_q        <= reject_d;
      results_valid_q <= results_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ballot fields, timer, counter and deferred close
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voter_number_q     <= '0;
      candidate_number_q <= '0;
      timer_q            <= '0;
      ballots_q          <= '0;
      close_pending_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, CLOSED: if (open_accept) ballots_q <= '0;
        OPEN:         if (!close_seen && bus.voter_valid) voter_number_q <= bus.voter_id;
        AUTH:         timer_q <= '0;
        WAIT_VOTE: begin
          timer_q <= timer_q + 1'b1;
          if (valid_press) candidate_number_q <= bus.cand_sel;
        end
        COMMIT: begin
          timer_q <= '0;
          if (ballots_q != BALLOT_MAX) ballots_q <= ballots_q + 1'b1;
        end
        HOLD:         timer_q <= timer_q + 1'b1;
        default:      ;
      endcase

      if ((state_q inside {AUTH, WAIT_VOTE, COMMIT, HOLD}) && bus.close_session)
        close_pending_q <= 1'b1;
      if (state_d == CLOSED)
        close_pending_q <= 1'b0;
    end
  end

  assign bus.vote_signal      = vote_signal_q;
  assign bus.voter_number     = voter_number_q;
  assign bus.candidate_number = candidate_number_q;
  assign bus.session_open     = session_open_q;
  assign bus.booth_ready      = booth_ready_q;
  assign bus.reject           = reject_q;
  assign bus.results_valid    = results_valid_q;
  assign bus.ballots_cast     = ballots_q;

endmodule : evm_session_controller

// File: tb/tb_evm_session_controller.sv
// -----------------------------------------------------------------------------
// tb_evm_session_controller
//   Directed session scenarios followed by randomized booth traffic, with
//   every output compared each cycle against a ballot-level model of the
//   session rules, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_evm_session_controller;

  localparam int VOTER_W        = evm_pkg::DEF_VOTER_W;
  localparam int CAND_W         = evm_pkg::DEF_CAND_W;
  localparam int NUM_CANDIDATES = evm_pkg::DEF_NUM_CANDIDATES;
  localparam int TIMEOUT_CYC    = evm_pkg::DEF_TIMEOUT_CYC;
  localparam int COMMIT_CYC     = evm_pkg::DEF_COMMIT_CYC;
  localparam int NUM_VOTERS     = 1 << VOTER_W;

  // Model phases of a session, as seen from the booth.
  localparam int P_OFF    = 0;  // before first opening
  localparam int P_READY  = 1;  // waiting for a login
  localparam int P_CHECK  = 2;  // identity being checked
  localparam int P_BALLOT = 3;  // waiting for a button press
  localparam int P_STROBE = 4;  // ballot being handed to the datapath
  localparam int P_SETTLE = 5;  // datapath settling time
  localparam int P_DONE   = 6;  // polls closed, results final

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  evm_session_controller_if #(.VOTER_W(VOTER_W), .CAND_W(CAND_W)) bus ();

  evm_session_controller #(
    .VOTER_W        (VOTER_W),
    .CAND_W         (CAND_W),
    .NUM_CANDIDATES (NUM_CANDIDATES),
    .TIMEOUT_CYC    (TIMEOUT_CYC),
    .COMMIT_CYC     (COMMIT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int strobes = 0;
  bit cmp_en  = 1'b0;

  // Behavioural model state
  int m_phase;
  bit m_voted [NUM_VOTERS];
  int m_count;
  int m_vnum;
  int m_cnum;
  int m_waited;
  int m_settle_left;
  bit m_close_req;
  bit m_reject;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase       = P_OFF;
    foreach (m_voted[i]) m_voted[i] = 1'b0;
    m_count       = 0;
    m_vnum        = 0;
    m_cnum        = 0;
    m_waited      = 0;
    m_settle_left = 0;
    m_close_req   = 1'b0;
    m_reject      = 1'b0;
  endfunction

  function automatic void model_new_session();
    m_phase = P_READY;
    foreach (m_voted[i]) m_voted[i] = 1'b0;
    m_count     = 0;
    m_close_req = 1'b0;
  endfunction

  // One clock edge of the session rules, using the inputs held across it.
  function automatic void model_step();
    bit op   = bus.open_session;
    bit cl   = bus.close_session;
    bit vv   = bus.voter_valid;
    int vid  = int'(bus.voter_id);
    bit vp   = bus.vote_press;
    int cand = int'(bus.cand_sel);
    m_reject = 1'b0;
    if (m_phase inside {P_CHECK, P_BALLOT, P_STROBE, P_SETTLE} && cl) m_close_req = 1'b1;
    case (m_phase)
      P_OFF, P_DONE: if (op) model_new_session();
      P_READY: begin
        if (cl || m_close_req) begin
          m_phase     = P_DONE;
          m_close_req = 1'b0;
        end else if (vv) begin
          m_vnum  = vid;
          m_phase = P_CHECK;
        end
      end
      P_CHECK: begin
        if (m_voted[m_vnum]) begin
          m_reject = 1'b1;
          m_phase  = P_READY;
        end else begin
          m_waited = 0;
          m_phase  = P_BALLOT;
        end
      end
      P_BALLOT: begin
        if (vp && cand < NUM_CANDIDATES) begin
          m_cnum  = cand;
          m_phase = P_STROBE;
        end else begin
          if (vp) m_reject = 1'b1;
          if (m_waited == TIMEOUT_CYC - 1) begin
            m_reject = 1'b1;
            m_phase  = P_READY;
          end else begin
            m_waited++;
          end
        end
      end
      P_STROBE: begin
        m_voted[m_vnum] = 1'b1;
        if (m_count < NUM_VOTERS) m_count++;
        m_settle_left = COMMIT_CYC - 1;
        m_phase       = P_SETTLE;
      end
      P_SETTLE: begin
        m_settle_left--;
        if (m_settle_left == 0) begin
          if (m_close_req) begin
            m_phase     = P_DONE;
            m_close_req = 1'b0;
          end else begin
            m_phase = P_READY;
          end
        end
      end
      default: m_phase = P_OFF;
    endcase
  endfunction

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("vote_signal",      int'(bus.vote_signal),      int'(m_phase == P_STROBE));
      check("session_open",     int'(bus.session_open),
            int'(m_phase inside {P_READY, P_CHECK, P_BALLOT, P_STROBE, P_SETTLE}));
      check("booth_ready",      int'(bus.booth_ready),      int'(m_phase == P_READY));
      check("results_valid",    int'(bus.results_valid),    int'(m_phase == P_DONE));
      check("reject",           int'(bus.reject),           int'(m_reject));
      check("voter_number",     int'(bus.voter_number),     m_vnum);
      check("candidate_number", int'(bus.candidate_number), m_cnum);
      check("ballots_cast",     int'(bus.ballots_cast),     m_count);
    end
  end

  always @(negedge clk) if (bus.vote_signal) strobes++;

  // Stimulus helpers: called at a falling edge, return at the next one.
  task automatic step_cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.open_session  = 1'b0;
    bus.close_session = 1'b0;
    bus.voter_valid   = 1'b0;
    bus.voter_id      = '0;
    bus.vote_press    = 1'b0;
    bus.cand_sel      = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic pulse_open();
    bus.open_session = 1'b1; step_cycle(); bus.open_session = 1'b0;
  endtask

  task automatic pulse_close();
    bus.close_session = 1'b1; step_cycle(); bus.close_session = 1'b0;
  endtask

  task automatic login(input int id);
    bus.voter_valid = 1'b1;
    bus.voter_id    = VOTER_W'(id);
    step_cycle();
    bus.voter_valid = 1'b0;
  endtask

  task automatic press(input int cand);
    bus.vote_press = 1'b1;
    bus.cand_sel   = CAND_W'(cand);
    step_cycle();
    bus.vote_press = 1'b0;
  endtask

  // Asynchronous reset between clock edges, held across one rising edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_vote"},   int'(bus.vote_signal),  0);
    check({tag, "_rst_open"},   int'(bus.session_open), 0);
    check({tag, "_rst_ballot"}, int'(bus.ballots_cast), 0);
    step_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    clear_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    idle(2);
    check("reset_session_open", int'(bus.session_open), 0);
    check("reset_ballots",      int'(bus.ballots_cast), 0);
    check("reset_results",      int'(bus.results_valid), 0);
    rst_n = 1'b1;

    // IDLE ignores logins.
    login(3);
    check("idle_ignores_login", int'(bus.session_open), 0);

    // 1: open, voter 0 votes for candidate 0.
    pulse_open();
    check("t1_booth_ready", int'(bus.booth_ready), 1);
    login(0);
    check("t1_left_open", int'(bus.booth_ready), 0);
    idle(1);
    s0 = strobes;
    press(0);
    check("t1_vote_signal", int'(bus.vote_signal), 1);
    check("t1_voter_number", int'(bus.voter_number), 0);
    check("t1_candidate", int'(bus.candidate_number), 0);
    idle(2);
    check("t1_ballots", int'(bus.ballots_cast), 1);
    check("t1_one_strobe", strobes - s0, 1);

    // 2: voter 0 again is rejected.
    login(0);
    idle(1);
    check("t2_reject", int'(bus.reject), 1);
    check("t2_back_open", int'(bus.booth_ready), 1);
    idle(1);
    check("t2_ballots", int'(bus.ballots_cast), 1);
    check("t2_no_strobe", strobes - s0, 1);

    // 3: voter 2, bad candidate then candidate 1; stray open ignored.
    login(2);
    idle(1);
    s0 = strobes;
    press(3);
    check("t3_bad_cand_reject", int'(bus.reject), 1);
    check("t3_still_waiting", int'(bus.session_open), 1);
    pulse_open();
    check("t3_open_ignored", int'(bus.ballots_cast), 1);
    press(1);
    check("t3_vote_signal", int'(bus.vote_signal), 1);
    check("t3_candidate", int'(bus.candidate_number), 1);
    check("t3_voter", int'(bus.voter_number), 2);
    idle(2);
    check("t3_ballots", int'(bus.ballots_cast), 2);
    check("t3_one_strobe", strobes - s0, 1);

    // 4: voter 5 times out, then votes.
    login(5);
    idle(1);
    idle(TIMEOUT_CYC - 1);
    check("t4_not_yet_timeout", int'(bus.reject), 0);
    idle(1);
    check("t4_timeout_reject", int'(bus.reject), 1);
    check("t4_back_open", int'(bus.booth_ready), 1);
    login(5);
    idle(1);
    press(2);
    check("t4_vote_signal", int'(bus.vote_signal), 1);
    idle(2);
    check("t4_ballots", int'(bus.ballots_cast), 3);

    // 4b: press on the final timeout cycle wins.
    login(6);
    idle(1);
    idle(TIMEOUT_CYC - 1);
    press(0);
    check("t4b_press_wins", int'(bus.vote_signal), 1);
    check("t4b_no_reject", int'(bus.reject), 0);
    idle(2);
    check("t4b_ballots", int'(bus.ballots_cast), 4);

    // 5: close during voter 4's ballot is deferred until it commits.
    login(4);
    idle(1);
    pulse_close();
    check("t5_close_deferred", int'(bus.session_open), 1);
    press(2);
    check("t5_vote_signal", int'(bus.vote_signal), 1);
    idle(1);
    check("t5_hold_open", int'(bus.session_open), 1);
    idle(1);
    check("t5_results_valid", int'(bus.results_valid), 1);
    check("t5_ballots", int'(bus.ballots_cast), 5);
    login(7);
    idle(1);
    check("t5_login_ignored", int'(bus.booth_ready), 0);
    check("t5_still_closed", int'(bus.results_valid), 1);

    // 6: reset during HOLD, reopen, same voter accepted.
    pulse_open();
    check("t6_reopen_clears", int'(bus.ballots_cast), 0);
    login(1);
    idle(1);
    press(0);
    idle(1);
    check("t6_in_hold", int'(bus.ballots_cast), 1);
    async_reset("t6");
    s0 = strobes;
    pulse_open();
    login(1);
    idle(1);
    press(0);
    check("t6_revote_signal", int'(bus.vote_signal), 1);
    check("t6_revote_voter", int'(bus.voter_number), 1);
    idle(2);
    check("t6_one_strobe", strobes - s0, 1);

    // Randomized booth traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.open_session  = ($urandom_range(15) == 0);
      bus.close_session = ($urandom_range(149) == 0);
      bus.voter_valid   = 1'($urandom_range(1));
      bus.voter_id      = VOTER_W'($urandom_range(NUM_VOTERS - 1));
      bus.vote_press    = ($urandom_range(2) == 0);
      bus.cand_sel      = CAND_W'($urandom_range((1 << CAND_W) - 1));
      if ($urandom_range(499) == 0) async_reset("rnd");
      else                          step_cycle();
    end
    clear_inputs();
    idle(2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_evm_session_controller
